// File: rtl/tri_bus_pkg.sv
// Shared state encoding and owner index width for the tri-state bus arbiter.
package tri_bus_pkg;

   localparam int OWNER_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN  = 2'd1,
      ST_TURN = 2'd2
   } state_t;

endpackage

// File: rtl/tri_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from last_owner+1, wrapping.
module rr_pick
   import tri_bus_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]   req,
   input  logic [OWNER_W-1:0] last_owner,
   output logic [OWNER_W-1:0] winner,
   output logic               any_req
);

   logic               found_hi;
   logic [OWNER_W-1:0] win_hi;
   logic [OWNER_W-1:0] win_lo;

   // Scanning downward lets the lowest qualifying index overwrite the others.
   always_comb begin
      found_hi = 1'b0;
      win_hi   = '0;
      win_lo   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            if (OWNER_W'(i) > last_owner) begin
               win_hi   = OWNER_W'(i);
               found_hi = 1'b1;
            end else begin
               win_lo = OWNER_W'(i);
            end
         end
      end
      winner  = found_hi ? win_hi : win_lo;
      any_req = |req;
   end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner of a shared tri-state bus with a high-Z turnaround gap between owners.
// Optional sticky bus contention detector: TRI_BUS_CONTENTION_CHECK_EN.
module tri_bus_arbiter
   import tri_bus_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int DATA_W     = 8,
   parameter int MAX_BURST  = 4,
   parameter int TURNAROUND = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*DATA_W-1:0]   wdata,
   output logic [N_REQ-1:0]          grant,
   inout  tri   [DATA_W-1:0]         bus,
   output logic                      bus_valid,
   output logic [OWNER_W-1:0]        owner_id,
   output logic                      contention_err
);

   state_t             state;
   logic [OWNER_W-1:0] last_owner;
   logic [3:0]         burst_cnt;
   logic [1:0]         turn_cnt;
   logic [OWNER_W-1:0] winner;
   logic               any_req;
   logic [N_REQ-1:0]   win_onehot;
   logic [DATA_W-1:0]  drive_dat;
   logic               drive_en;
   logic               own_req;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req        (req),
      .last_owner (last_owner),
      .winner     (winner),
      .any_req    (any_req)
   );

   assign win_onehot = N_REQ'(1) << winner;

   // Everything below keys off the registered grant, so an async reset releases the bus at once.
   always_comb begin
      drive_dat = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) drive_dat = wdata[i*DATA_W +: DATA_W];
      end
   end

   assign drive_en  = (state == ST_OWN);
   assign own_req   = |(grant & req);
   assign bus_valid = drive_en && own_req;
   assign bus       = drive_en ? drive_dat : {DATA_W{1'bz}};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         grant      <= '0;
         owner_id   <= '0;
         last_owner <= OWNER_W'(N_REQ - 1);
         burst_cnt  <= '0;
         turn_cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  state      <= ST_OWN;
                  grant      <= win_onehot;
                  owner_id   <= winner;
                  last_owner <= winner;
                  burst_cnt  <= '0;
               end
            end
            ST_OWN: begin
               burst_cnt <= burst_cnt + 4'd1;
               if (!own_req || burst_cnt == 4'(MAX_BURST - 1)) begin
                  state    <= ST_TURN;
                  grant    <= '0;
                  owner_id <= '0;
                  turn_cnt <= '0;
               end
            end
            ST_TURN: begin
               turn_cnt <= turn_cnt + 2'd1;
               if (turn_cnt == 2'(TURNAROUND - 1)) begin
                  if (any_req) begin
                     state      <= ST_OWN;
                     grant      <= win_onehot;
                     owner_id   <= winner;
                     last_owner <= winner;
                     burst_cnt  <= '0;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: begin
               state    <= ST_IDLE;
               grant    <= '0;
               owner_id <= '0;
            end
         endcase
      end
   end

`ifdef TRI_BUS_CONTENTION_CHECK_EN
   // Case-inequality so X or Z on the resolved net also counts as a collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         contention_err <= 1'b0;
      end else if (drive_en && (bus !== drive_dat)) begin
         contention_err <= 1'b1;
      end
   end
`else
   assign contention_err = 1'b0;
`endif

   grant_onehot_a: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed bench for tri_bus_arbiter; bus net is pulled up, so a released bus reads as all ones.
module tb_tri_bus_arbiter;

   localparam int N_REQ  = 4;
   localparam int DATA_W = 8;
   localparam logic [7:0] REL = 8'hFF;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [N_REQ-1:0]        req;
   logic [N_REQ*DATA_W-1:0] wdata;
   logic [N_REQ-1:0]        grant;
   tri1  [DATA_W-1:0]       bus;
   logic                    bus_valid;
   logic [2:0]              owner_id;
   logic                    contention_err;

   int n_checks = 0;
   int n_errors = 0;

`ifdef TRI_BUS_CONTENTION_CHECK_EN
   logic foreign_en = 1'b0;
   assign bus = foreign_en ? 8'h00 : 8'hzz;
`endif

   always #5 clk = ~clk;

   tri_bus_arbiter #(
      .N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_BURST(4), .TURNAROUND(1)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req            (req),
      .wdata          (wdata),
      .grant          (grant),
      .bus            (bus),
      .bus_valid      (bus_valid),
      .owner_id       (owner_id),
      .contention_err (contention_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_own(input string tag, input logic [3:0] g, input logic [2:0] id,
                          input logic [7:0] d, input logic v);
      chk({tag, "_grant"}, 32'(grant), 32'(g));
      chk({tag, "_owner"}, 32'(owner_id), 32'(id));
      chk({tag, "_bus"}, 32'(bus), 32'(d));
      chk({tag, "_valid"}, 32'(bus_valid), 32'(v));
   endtask

   task automatic chk_rel(input string tag);
      chk({tag, "_grant"}, 32'(grant), 32'h0);
      chk({tag, "_owner"}, 32'(owner_id), 32'h0);
      chk({tag, "_bus"}, 32'(bus), 32'(REL));
      chk({tag, "_valid"}, 32'(bus_valid), 32'h0);
   endtask

   initial begin
      logic [7:0] wd [4];
      logic [3:0] oh;
      wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33; wd[3] = 8'h44;

      // Reset with every requester asserting.
      rst   = 1'b1;
      req   = 4'b1111;
      wdata = {wd[3], wd[2], wd[1], wd[0]};
      #3;
      chk_rel("rst_hold");
      chk("rst_cerr", 32'(contention_err), 32'h0);
      step();
      step();
      rst = 1'b0;
      #1;
      chk("pre_first_edge_grant", 32'(grant), 32'h0);

      // Full round robin: 4 owned cycles per grant, one released cycle between.
      for (int g = 0; g < 5; g++) begin
         oh = 4'b0001 << (g % 4);
         for (int c = 0; c < 4; c++) begin
            step();
            chk_own($sformatf("rr_g%0d_c%0d", g, c), oh, 3'(g % 4), wd[g % 4], 1'b1);
         end
         step();
         chk_rel($sformatf("rr_turn%0d", g));
      end
      chk("rr_cerr", 32'(contention_err), 32'h0);

      // Single continuous requester.
      rst = 1'b1;
      req = 4'b0100;
      wdata[2*DATA_W +: DATA_W] = 8'hA5;
      step();
      rst = 1'b0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 4; c++) begin
            step();
            chk_own($sformatf("single_r%0d_c%0d", r, c), 4'b0100, 3'd2, 8'hA5, 1'b1);
         end
         step();
         chk_rel($sformatf("single_turn%0d", r));
      end

      // Early release after two owned cycles.
      rst = 1'b1;
      req = 4'b0010;
      wdata[1*DATA_W +: DATA_W] = 8'h5A;
      step();
      rst = 1'b0;
      step();
      chk_own("early_c0", 4'b0010, 3'd1, 8'h5A, 1'b1);
      step();
      chk_own("early_c1", 4'b0010, 3'd1, 8'h5A, 1'b1);
      step();
      req = 4'b0000;
      #1;
      chk_own("early_drop", 4'b0010, 3'd1, 8'h5A, 1'b0);
      step();
      chk_rel("early_turn");
      step();
      chk_rel("early_idle0");
      step();
      chk_rel("early_idle1");

      // Reset during the third owned cycle of requester 2.
      rst = 1'b1;
      req = 4'b0100;
      step();
      rst = 1'b0;
      step();
      step();
      step();
      chk_own("midrst_c2", 4'b0100, 3'd2, 8'hA5, 1'b1);
      req = 4'b1111;
      #1;
      rst = 1'b1;
      #1;
      chk_rel("midrst_async");
      step();
      rst = 1'b0;
      step();
      chk_own("midrst_restart", 4'b0001, 3'd0, wd[0], 1'b1);

      // Contention detection.
      rst = 1'b1;
      req = 4'b0001;
      wdata[0 +: DATA_W] = 8'hFF;
      step();
      rst = 1'b0;
      step();
      chk("cont_pre", 32'(contention_err), 32'h0);
`ifdef TRI_BUS_CONTENTION_CHECK_EN
      foreign_en = 1'b1;
      step();
      foreign_en = 1'b0;
      chk("cont_set", 32'(contention_err), 32'h1);
      for (int c = 0; c < 5; c++) step();
      chk("cont_sticky", 32'(contention_err), 32'h1);
      rst = 1'b1;
      #1;
      chk("cont_clear", 32'(contention_err), 32'h0);
      rst = 1'b0;
`else
      for (int c = 0; c < 5; c++) step();
      chk("cont_off", 32'(contention_err), 32'h0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/tri_bus_arbiter.md
Name: tri_bus_arbiter

Overview:
- Round-robin arbiter and driver for a shared tri-state data bus (`tri` net).
- Up to N_REQ requesters compete for the bus. The winner's data is driven onto the bus; every other time the bus is released to high-Z.
- A guaranteed high-Z turnaround gap separates owners, so the multi-driver nets downstream never see two active drivers.
- Sits directly upstream of the wired/tri net resolution stage and is the only active driver of the `tri` bus it feeds.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 8, bus data width.
- MAX_BURST, 4, maximum consecutive owned cycles per grant (1..15).
- TURNAROUND, 1, high-Z cycles between owners (1..3; 0 is illegal).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-requester bus request, level-sensitive.
- wdata  input  N_REQ*DATA_W  requester i's data in slice [i*DATA_W +: DATA_W].
- grant  output  N_REQ  one-hot registered grant; all-zero when no owner.
- bus  inout  DATA_W  shared `tri` bus; driven only in OWN, else high-Z.
- bus_valid  output  1  bus carries valid owner data this cycle.
- owner_id  output  3  index of current owner; 0 when grant is all-zero.
- contention_err  output  1  sticky contention flag (see Optional Feature).

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, grant=0, owner_id=0, bus=Z, bus_valid=0.
  - burst_cnt=0, turn_cnt=0, last_owner=N_REQ-1 (requester 0 has first priority), contention_err=0.
- Reset asserted mid-OWN: bus goes to Z and grant goes to 0 immediately, without waiting for a clock edge.
- States: IDLE, OWN, TURN (2-bit encoding).
- IDLE:
  - If any req bit is high at an edge, select the first set bit searching upward from last_owner+1, modulo N_REQ.
  - Next cycle: state=OWN, grant=onehot(winner), last_owner=winner, burst_cnt=0.
  - Latency from request to grant: 1 cycle.
- OWN:
  - bus = wdata[owner], combinational from the registered grant.
  - bus_valid = req[owner].
  - burst_cnt increments every edge.
  - Exit to TURN at the edge where req[owner]=0 OR burst_cnt==MAX_BURST-1. At that edge grant←0 and turn_cnt←0.
  - Requests from other requesters have no effect while OWN (no pre-emption).
- TURN:
  - bus=Z, bus_valid=0, grant=0.
  - turn_cnt increments each cycle. At the edge where turn_cnt==TURNAROUND-1:
    - any req high: arbitrate as in IDLE and go directly to OWN;
    - otherwise go to IDLE.
- Round-robin fairness: a requester that held MAX_BURST cycles and is still requesting cannot win again while any other requester is asserting req.
- A single continuous requester gets MAX_BURST owned cycles, then TURNAROUND Z cycles, repeating.
- owner_id tracks the grant encoding. grant is never more than one-hot; this is an assertion target.
- bus is never driven in IDLE or TURN.

Optional Feature:
- Macro: TRI_BUS_CONTENTION_CHECK_EN.
- Defined:
  - Each OWN cycle, the resolved bus is compared with the value being driven, using case-inequality, so X and Z count as mismatches.
  - Any mismatch sets contention_err, registered and sticky until rst.
  - Catches a foreign driver or an unresolved net.
- Not defined: contention_err is tied to 0 and the comparator is not compiled.

Decomposition:
- Package tri_bus_pkg holds:
  - state localparams ST_IDLE=2'd0, ST_OWN=2'd1, ST_TURN=2'd2;
  - the 2-bit state typedef;
  - the owner_id width constant.
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: req vector, last_owner.
  - Outputs: winner index and any_req.
  - Instantiated once.

Test Plan:
- Reset behaviour: hold rst, drive req=4'b1111 → grant=0, bus=Z, bus_valid=0, owner_id=0. After release, first grant=4'b0001 exactly 1 cycle later.
- Single long requester: req=4'b0100 held, wdata[2]=8'hA5, MAX_BURST=4, TURNAROUND=1 → bus=A5 for 4 cycles, Z for 1 cycle, A5 again for 4 cycles, repeating.
- Early release: req[1] drops after 2 owned cycles → bus_valid=0 in the drop cycle, then TURN 1 cycle, then IDLE. Bus is Z throughout TURN and IDLE.
- Full round-robin: all four requesting continuously, distinct wdata → grant sequence 0001, 0010, 0100, 1000, 0001. Each grant lasts 4 cycles, with 1 Z cycle between grants; grant is never multi-hot.
- Reset mid-burst: assert rst during the third OWN cycle → bus=Z and grant=0 before the next edge. After release, arbitration restarts at requester 0.
- Contention (macro defined): during OWN, an external force drives the bus to 8'h00 while the owner drives 8'hFF → contention_err=1 on the next edge and stays 1 until rst. With the macro undefined, contention_err stays 0.
